pcs_block_sync_rx: RTL and testbench
====================================

// Module: pcs_block_sync_rx
// PURPOSE
//  Receive-side 64b/66b block synchronisation (802.3 Cl.49/82 lock FSM), one lane.
//  Sits between the rx gearbox and the descrambler/pcs_dec_lite. Checks sync headers
//  and asserts block lock. While unlocked, pulses slip to the gearbox until 66-bit
//  boundaries align. Forwards head/data to the decoder with one cycle of latency.
// PARAMETERS
//  IS_40G        1     1: 40GBASE-R lock thresholds, 0: 10GBASE-R
//  HEAD_W        2     sync header width
//  DATA_W        64    block payload width
//  SH_CNT_MAX    IS_40G?1024:64  valid headers per test window
//  SH_INVLD_MAX  IS_40G?65:16    invalid headers in a window that drop lock
//  SLIP_WAIT     2     valid_i blocks ignored after a slip (gearbox settle)
// PORTS
//  clk          in   1       clock
//  nreset       in   1       asynchronous reset, active low
//  signal_ok_i  in   1       PMA signal detect; low forces unlocked
//  valid_i      in   1       gearbox block valid (may have gaps)
//  head_i       in   HEAD_W  sync header
//  data_i       in   DATA_W  block payload
//  slip_v_o     out  1       one-cycle request: gearbox shifts alignment by one bit
//  lock_v_o     out  1       block_lock
//  valid_o      out  1       registered valid_i & lock (lock value before update)
//  head_o       out  HEAD_W  registered head_i
//  data_o       out  DATA_W  registered data_i
// BEHAVIOUR
//  Reset: state=INIT, counters 0; lock_v_o=0, slip_v_o=0, valid_o=0, head_o=0, data_o=0.
//  sh_ok = (head_i==2'b01)|(head_i==2'b10). Only cycles with valid_i=1 are evaluated.
//  States: INIT, TEST, SLIP.
//   INIT: lock=0 and counters cleared. Goes to TEST on the first cycle with signal_ok_i=1.
//   TEST, per valid block: sh_cnt+1; if !sh_ok, sh_invld_cnt+1.
//    - Unlocked and !sh_ok: go to SLIP.
//    - Locked and sh_invld_cnt+1==SH_INVLD_MAX: lock<=0, go to SLIP.
//    - sh_cnt+1==SH_CNT_MAX without a slip: counters clear.
//      If sh_invld_cnt==0 (unlocked case), lock<=1.
//      Already-locked: lock stays 1.
//   SLIP: slip_v_o=1 for exactly the entry cycle and lock=0.
//    Counters cleared. Then SLIP_WAIT valid blocks are discarded.
//    After that, state returns to TEST.
//  signal_ok_i=0 in any state: next cycle state=INIT, lock_v_o=0, no slip pulse.
//  Counter widths: $clog2(SH_CNT_MAX+1). Counters never wrap; they saturate at clear points.
//  valid_i=0: counters, state and wait count hold. valid_o=0 on the next cycle.
//  head_o/data_o always register the inputs. Latency is 1 cycle.
//  lock_v_o changes on the cycle after the deciding block.
//  Async reset mid-window: all state is dropped immediately; acquisition restarts from INIT.
// STRUCTURE
//  Shared package pcs_pkg:
//   - SYNC_HEAD_CTRL/SYNC_HEAD_DATA
//   - sync thresholds for 10G/40G
//   - state enum typedef
//  No sub-module. FSM, two counters, slip-wait counter and output registers are
//  all implemented inline.
// TESTING
//  1 Hold nreset=0 with random inputs -> lock_v_o=0, slip_v_o=0, valid_o=0 throughout.
//  2 IS_40G=0, signal_ok_i=1, 64 consecutive blocks with head 01/10 alternating:
//    - lock_v_o rises the cycle after block 64.
//    - valid_o stays 0 until then.
//    - IS_40G=1 needs 1024 blocks.
//  3 Unlocked, head 2'b00 at block 5:
//    - single slip_v_o pulse.
//    - next 2 valid blocks ignored.
//    - lock only after 64 further good blocks.
//  4 Locked, 15 invalid headers in a 64-block window:
//    - lock holds, no slip.
//    - 16th invalid in the same window -> lock_v_o=0 and slip_v_o pulse the next cycle.
//  5 valid_i low every 3rd cycle during acquisition:
//    - counters hold.
//    - lock after exactly 64 valid blocks.
//    - valid_o mirrors the gaps.
//  6 Locked, then signal_ok_i=0 for 1 cycle -> lock_v_o=0 next cycle, no slip.
//    Reacquire after 64 good blocks.
//    Async nreset pulse mid-window -> outputs zero immediately.

Source files
------------

// File: rtl/pcs_pkg.sv
// pcs_pkg: shared 64b/66b PCS sync-header codes, lock thresholds and block-sync state type
package pcs_pkg;
  localparam logic [1:0] SYNC_HEAD_DATA = 2'b01;
  localparam logic [1:0] SYNC_HEAD_CTRL = 2'b10;
  localparam int SH_CNT_MAX_10G = 64;
  localparam int SH_CNT_MAX_40G = 1024;
  localparam int SH_INVLD_MAX_10G = 16;
  localparam int SH_INVLD_MAX_40G = 65;
  typedef enum logic [1:0] {ST_INIT, ST_TEST, ST_SLIP} sync_state_e;
endpackage

// File: rtl/pcs_block_sync_rx.sv
// pcs_block_sync_rx: 64b/66b rx block lock FSM, slips the gearbox until sync headers align
// ports: clk/nreset (async, active low); signal_ok_i PMA detect; valid_i/head_i/data_i from gearbox;
//        slip_v_o one-cycle bit-slip request; lock_v_o block_lock; valid_o/head_o/data_o to decoder (1-cycle latency)
module pcs_block_sync_rx
  import pcs_pkg::*;
#(
  parameter bit IS_40G       = 1,
  parameter int HEAD_W       = 2,
  parameter int DATA_W       = 64,
  parameter int SH_CNT_MAX   = IS_40G ? SH_CNT_MAX_40G : SH_CNT_MAX_10G,
  parameter int SH_INVLD_MAX = IS_40G ? SH_INVLD_MAX_40G : SH_INVLD_MAX_10G,
  parameter int SLIP_WAIT    = 2
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              signal_ok_i,
  input  logic              valid_i,
  input  logic [HEAD_W-1:0] head_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              slip_v_o,
  output logic              lock_v_o,
  output logic              valid_o,
  output logic [HEAD_W-1:0] head_o,
  output logic [DATA_W-1:0] data_o
);
  localparam int CW = $clog2(SH_CNT_MAX + 1);
  localparam int WW = $clog2(SLIP_WAIT + 1);
  sync_state_e state, state_n;
  logic [CW-1:0] sh_cnt, sh_cnt_n, invld, invld_n, sh_cnt_inc, invld_inc;
  logic [WW-1:0] wait_cnt, wait_n;
  logic lock_n, slip_n, sh_ok;
  assign sh_ok = (head_i == HEAD_W'(SYNC_HEAD_DATA)) || (head_i == HEAD_W'(SYNC_HEAD_CTRL));
  assign sh_cnt_inc = sh_cnt + CW'(1);
  assign invld_inc = invld + CW'(!sh_ok);
  always_comb begin
    state_n = state;
    sh_cnt_n = sh_cnt;
    invld_n = invld;
    wait_n = wait_cnt;
    lock_n = lock_v_o;
    slip_n = 1'b0;
    if (!signal_ok_i) begin
      state_n = ST_INIT;
      sh_cnt_n = '0;
      invld_n = '0;
      wait_n = '0;
      lock_n = 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          state_n = ST_TEST;
          sh_cnt_n = '0;
          invld_n = '0;
          wait_n = '0;
          lock_n = 1'b0;
        end
        ST_TEST: if (valid_i) begin
          if ((!lock_v_o && !sh_ok) || (lock_v_o && invld_inc == CW'(SH_INVLD_MAX))) begin
            state_n = ST_SLIP;
            slip_n = 1'b1;
            lock_n = 1'b0;
            sh_cnt_n = '0;
            invld_n = '0;
            wait_n = '0;
          end else if (sh_cnt_inc == CW'(SH_CNT_MAX)) begin
            sh_cnt_n = '0;
            invld_n = '0;
            lock_n = lock_v_o || (invld == '0);
          end else begin
            sh_cnt_n = sh_cnt_inc;
            invld_n = invld_inc;
          end
        end
        ST_SLIP: if (valid_i) begin
          wait_n = wait_cnt + WW'(1);
          state_n = (wait_n == WW'(SLIP_WAIT)) ? ST_TEST : ST_SLIP;
          wait_n = (wait_n == WW'(SLIP_WAIT)) ? '0 : wait_n;
        end
        default: state_n = ST_INIT;
      endcase
    end
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= ST_INIT;
      sh_cnt <= '0;
      invld <= '0;
      wait_cnt <= '0;
      lock_v_o <= 1'b0;
      slip_v_o <= 1'b0;
      valid_o <= 1'b0;
      head_o <= '0;
      data_o <= '0;
    end else begin
      state <= state_n;
      sh_cnt <= sh_cnt_n;
      invld <= invld_n;
      wait_cnt <= wait_n;
      lock_v_o <= lock_n;
      slip_v_o <= slip_n;
      valid_o <= valid_i & lock_v_o;
      head_o <= head_i;
      data_o <= data_i;
    end
  end
endmodule

// File: tb/tb_pcs_block_sync_rx.sv
// tb_pcs_block_sync_rx: randomized self-checking bench for 10G block lock against a behavioural model
module tb_pcs_block_sync_rx;
  localparam int HW = 2;
  localparam int DW = 64;
  localparam int CNT = 64;
  localparam int INV = 16;
  localparam int SW = 2;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic signal_ok_i = 1'b0;
  logic valid_i = 1'b0;
  logic [HW-1:0] head_i = '0;
  logic [DW-1:0] data_i = '0;
  logic slip_v_o, lock_v_o, valid_o;
  logic [HW-1:0] head_o;
  logic [DW-1:0] data_o;
  int n_cmp = 0;
  int n_bad = 0;
  int m_mode, m_cnt, m_inv, m_wait;
  logic m_lock, m_slip, m_vo;
  logic [HW-1:0] m_ho;
  logic [DW-1:0] m_do;
  logic [DW+HW+2:0] got;
  always #5 clk = ~clk;
  pcs_block_sync_rx #(.IS_40G(1'b0)) dut (
    .clk(clk), .nreset(nreset), .signal_ok_i(signal_ok_i), .valid_i(valid_i),
    .head_i(head_i), .data_i(data_i), .slip_v_o(slip_v_o), .lock_v_o(lock_v_o),
    .valid_o(valid_o), .head_o(head_o), .data_o(data_o)
  );
  assign got = {lock_v_o, slip_v_o, valid_o, head_o, data_o};
  function automatic logic [DW+HW+2:0] expv();
    return {m_lock, m_slip, m_vo, m_ho, m_do};
  endfunction
  function automatic logic [HW-1:0] gh();
    return $urandom_range(0, 1) ? 2'b01 : 2'b10;
  endfunction
  function automatic logic [HW-1:0] bh();
    return $urandom_range(0, 1) ? 2'b00 : 2'b11;
  endfunction
  function automatic logic [DW-1:0] rd();
    return {$urandom, $urandom};
  endfunction
  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_inv = 0; m_wait = 0;
    m_lock = 0; m_slip = 0; m_vo = 0; m_ho = '0; m_do = '0;
  endtask
  // mode 0: waiting for signal, 1: counting headers, 2: discarding blocks after a slip
  task automatic model_step(input logic sok, input logic v, input logic [HW-1:0] h, input logic [DW-1:0] d);
    bit good;
    good = (h == 2'b01) || (h == 2'b10);
    m_vo = v & m_lock;
    m_ho = h;
    m_do = d;
    m_slip = 0;
    if (!sok) begin
      m_mode = 0; m_cnt = 0; m_inv = 0; m_wait = 0; m_lock = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (v && m_mode == 2) begin
      m_wait++;
      if (m_wait == SW) begin m_mode = 1; m_wait = 0; end
    end else if (v && m_mode == 1) begin
      m_cnt++;
      if (!good) m_inv++;
      if ((!m_lock && !good) || (m_lock && m_inv == INV)) begin
        m_lock = 0; m_slip = 1; m_mode = 2; m_cnt = 0; m_inv = 0;
      end else if (m_cnt == CNT) begin
        m_lock = 1; m_cnt = 0; m_inv = 0;
      end
    end
  endtask
  task automatic drive(input logic sok, input logic v, input logic [HW-1:0] h, input logic [DW-1:0] d);
    signal_ok_i = sok; valid_i = v; head_i = h; data_i = d;
    @(posedge clk);
    if (nreset) model_step(sok, v, h, d); else model_reset();
    #1;
  endtask
  task automatic restart();
    drive(1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, '0, '0);
  endtask
  task automatic acquire();
    restart();
    for (int i = 0; i < CNT; i++) drive(1'b1, 1'b1, gh(), rd());
  endtask
  task automatic test_reset();
    nreset = 0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), HW'($urandom), rd());
      n_cmp++;
      if (got !== '0) begin n_bad++; $display("FAIL reset cyc%0d got=%h exp=0", i, got); end
    end
    nreset = 1;
  endtask
  task automatic test_acquire();
    int rise = 0;
    restart();
    for (int i = 1; i <= 70; i++) begin
      drive(1'b1, 1'b1, (i % 2) ? 2'b01 : 2'b10, rd());
      n_cmp++;
      if (got !== expv()) begin n_bad++; $display("FAIL acquire blk%0d got=%h exp=%h", i, got, expv()); end
      if (lock_v_o && rise == 0) rise = i;
    end
    n_cmp++;
    if (rise != CNT) begin n_bad++; $display("FAIL acquire_rise got=%0d exp=%0d", rise, CNT); end
  endtask
  task automatic test_slip();
    int rise = 0;
    int slips = 0;
    restart();
    for (int i = 1; i <= 75; i++) begin
      drive(1'b1, 1'b1, (i == 5) ? 2'b00 : gh(), rd());
      n_cmp++;
      if (got !== expv()) begin n_bad++; $display("FAIL slip blk%0d got=%h exp=%h", i, got, expv()); end
      if (i == 5) begin
        n_cmp++;
        if (slip_v_o !== 1'b1) begin n_bad++; $display("FAIL slip_pulse got=%b exp=1", slip_v_o); end
      end
      slips += int'(slip_v_o);
      if (lock_v_o && rise == 0) rise = i;
    end
    n_cmp++;
    if (slips != 1) begin n_bad++; $display("FAIL slip_count got=%0d exp=1", slips); end
    n_cmp++;
    if (rise != 5 + SW + CNT) begin n_bad++; $display("FAIL slip_relock got=%0d exp=%0d", rise, 5 + SW + CNT); end
  endtask
  task automatic test_locked_invalid();
    int slips = 0;
    acquire();
    n_cmp++;
    if (lock_v_o !== 1'b1) begin n_bad++; $display("FAIL inv_prelock got=%b exp=1", lock_v_o); end
    for (int i = 1; i <= CNT; i++) begin
      drive(1'b1, 1'b1, (i % 4 == 1 && i <= 57) ? bh() : gh(), rd());
      n_cmp++;
      if (got !== expv()) begin n_bad++; $display("FAIL inv15 blk%0d got=%h exp=%h", i, got, expv()); end
      slips += int'(slip_v_o) + int'(!lock_v_o);
    end
    n_cmp++;
    if (slips != 0) begin n_bad++; $display("FAIL inv15_hold got=%0d exp=0", slips); end
    for (int i = 1; i <= INV; i++) begin
      drive(1'b1, 1'b1, bh(), rd());
      n_cmp++;
      if (got !== expv()) begin n_bad++; $display("FAIL inv16 blk%0d got=%h exp=%h", i, got, expv()); end
    end
    n_cmp++;
    if ({lock_v_o, slip_v_o} !== 2'b01) begin n_bad++; $display("FAIL inv16_drop got=%b exp=01", {lock_v_o, slip_v_o}); end
  endtask
  task automatic test_gaps();
    int nv = 0;
    int rise = 0;
    restart();
    for (int i = 0; i < 110; i++) begin
      drive(1'b1, i % 3 != 2, gh(), rd());
      nv += (i % 3 != 2) ? 1 : 0;
      n_cmp++;
      if (got !== expv()) begin n_bad++; $display("FAIL gaps cyc%0d got=%h exp=%h", i, got, expv()); end
      if (lock_v_o && rise == 0) rise = nv;
    end
    n_cmp++;
    if (rise != CNT) begin n_bad++; $display("FAIL gaps_rise got=%0d exp=%0d", rise, CNT); end
  endtask
  task automatic test_signal_loss();
    acquire();
    drive(1'b0, 1'b1, gh(), rd());
    n_cmp++;
    if ({lock_v_o, slip_v_o} !== 2'b00 || got !== expv()) begin n_bad++; $display("FAIL sigloss got=%h exp=%h", got, expv()); end
    drive(1'b1, 1'b0, '0, '0);
    for (int i = 1; i <= CNT; i++) begin
      drive(1'b1, 1'b1, gh(), rd());
      n_cmp++;
      if (got !== expv()) begin n_bad++; $display("FAIL sigloss_reacq blk%0d got=%h exp=%h", i, got, expv()); end
    end
    n_cmp++;
    if (lock_v_o !== 1'b1) begin n_bad++; $display("FAIL sigloss_lock got=%b exp=1", lock_v_o); end
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, gh(), rd());
    #2;
    nreset = 0;
    model_reset();
    #1;
    n_cmp++;
    if (got !== '0) begin n_bad++; $display("FAIL async_reset got=%h exp=0", got); end
    #1;
    nreset = 1;
    drive(1'b1, 1'b0, '0, '0);
    for (int i = 1; i <= CNT; i++) drive(1'b1, 1'b1, gh(), rd());
    n_cmp++;
    if (lock_v_o !== 1'b1 || got !== expv()) begin n_bad++; $display("FAIL async_reacq got=%h exp=%h", got, expv()); end
  endtask
  task automatic test_random();
    int rate;
    for (int p = 0; p < 6; p++) begin
      rate = (p % 3 == 0) ? 0 : (p % 3 == 1) ? 1 : 30;
      for (int i = 0; i < 200; i++) begin
        drive(1'($urandom_range(0, 149) != 0), 1'($urandom_range(0, 3) != 0),
              (int'($urandom_range(0, 99)) < rate) ? bh() : gh(), rd());
        n_cmp++;
        if (got !== expv()) begin n_bad++; $display("FAIL random p%0d cyc%0d got=%h exp=%h", p, i, got, expv()); end
      end
    end
  endtask
  initial begin
    test_reset();
    test_acquire();
    test_slip();
    test_locked_invalid();
    test_gaps();
    test_signal_loss();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
